btb_assoc: RTL and testbench
============================

// Module: btb_assoc
// PURPOSE
//  Parametrised set-associative branch target buffer; successor to the single-table BTB in the fetch path.
//  Same-cycle lookup on the IF PC gives target, hit and taken prediction. Resolved branches from MEM train it.
//  Per-entry saturating counters give the direction; a per-set round-robin pointer picks the victim.
//  Built-in saturating counters (lookups/hits/mispredicts) feed the benchmarking flow.
// PARAMETERS
//  XLEN      32  address/target width
//  ENTRIES   64  total entries; power of two, >= WAYS
//  WAYS      2   associativity; power of two, 1..8
//  CTR_BITS  2   direction counter width, >= 1
//  STAT_W    32  statistics counter width
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset
//  pc              in   XLEN     fetch PC to look up
//  lookup_en       in   1        fetch advancing this cycle (pc_en); qualifies statistics only
//  target_pc       out  XLEN     predicted target on hit, else pc+4
//  valid           out  1        lookup hit
//  predictedTaken  out  1        hit and counter MSB set
//  update          in   1        train with a resolved control-transfer instruction
//  update_pc       in   XLEN     PC of the resolved instruction
//  update_target   in   XLEN     resolved target
//  update_taken    in   1        actual direction
//  mispredicted    in   1        redirect issued this cycle (statistics only)
//  flush_all       in   1        invalidate all entries
//  stat_clear      in   1        zero statistics counters
//  stat_lookups    out  STAT_W   count of lookup_en cycles
//  stat_hits       out  STAT_W   count of lookup_en && valid cycles
//  stat_mispred    out  STAT_W   count of mispredicted cycles
// BEHAVIOUR
//  - Reset: one clock (clk); reset (rst) is asynchronous and active-high.
//  - Reset state: all valid bits 0; counters set to weak-taken 2^(CTR_BITS-1); round-robin pointers 0; stats 0.
//    Outputs after reset: valid=0, predictedTaken=0, target_pc=pc+4.
//  - Address split: SETS=ENTRIES/WAYS; IDX=log2(SETS); index=pc[IDX+1:2]; tag=pc[XLEN-1:IDX+2] (full tag).
//    SETS=1 means IDX=0 and no index bits are used.
//  - Lookup: purely combinational, zero latency. At most one way matches; update logic guarantees this.
//    With no match: target_pc=pc+4 and predictedTaken=0. pc+4 wraps modulo 2^XLEN.
//  - Update is sequential on the rising clk edge while update=1.
//    Hit in set(update_pc): target is written only if update_taken=1.
//    The counter saturates: +1 when taken, capped at all-ones; -1 when not taken, floored at 0.
//  - Update miss, taken: allocate into the lowest-index invalid way. If none is invalid, use the way at the
//    set's round-robin pointer, then advance the pointer by 1 modulo WAYS.
//    The new entry gets valid=1, tag, target and counter=weak-taken.
//  - Update miss, not taken: no state change.
//  - Lookup and update in the same cycle (same set or same entry): lookup sees pre-edge state; no bypass.
//  - flush_all: clears every valid bit at the edge and resets pointers to 0.
//    It takes priority over a same-cycle update, so the update is dropped. Stats are not affected.
//  - Stats: increment on their qualifiers, saturate at all-ones and never wrap.
//    stat_clear zeroes all three at the edge and beats a same-cycle increment.
//  - Reset mid-operation: an asynchronous return to the reset state. Any in-flight update is lost.
// TESTING
//  1) Reset, pc=0x100 -> valid=0, predictedTaken=0, target_pc=0x104; all stats 0.
//  2) Update pc=0x100, target=0x200, taken=1; next cycle lookup 0x100 -> valid=1, predictedTaken=1 (ctr=2),
//     target 0x200. One not-taken update -> ctr=1, predictedTaken=0, valid=1.
//  3) WAYS=2, ENTRIES=64: taken updates to 0x100, 0x180, 0x200 (same set 0).
//     The third evicts the way-0 entry (0x100); 0x180 and 0x200 hit, 0x100 misses. Pointer becomes 1.
//  4) Four taken updates with CTR_BITS=2 -> ctr=3, no overflow. Five not-taken -> ctr=0, no underflow.
//     Not-taken update to an absent pc 0x300 -> 0x300 still misses.
//  5) flush_all and update to 0x400 in the same cycle -> every lookup misses next cycle, including 0x400.
//  6) STAT_W=4: 20 lookup_en cycles -> stat_lookups=15, held. stat_clear with lookup_en=1 -> 0.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction counters,
// per-set round-robin replacement and saturating lookup/hit/mispredict statistics.
module btb_assoc #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic              lookup_en,
  output logic [XLEN-1:0]   target_pc,
  output logic              valid,
  output logic              predictedTaken,
  input  logic              update,
  input  logic [XLEN-1:0]   update_pc,
  input  logic [XLEN-1:0]   update_target,
  input  logic              update_taken,
  input  logic              mispredicted,
  input  logic              flush_all,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX   = $clog2(SETS);
  localparam int IDX_W = (IDX > 0) ? IDX : 1;
  localparam int TAG_W = XLEN - IDX - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic                valid_reg  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_reg    [SETS][WAYS];
  logic [XLEN-1:0]     target_reg [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_reg    [SETS][WAYS];
  logic [WAY_W-1:0]    ptr_reg    [SETS];

  logic [IDX_W-1:0] l_set, u_set;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [WAYS-1:0]  l_match, u_match, u_free;
  logic [WAY_W-1:0] l_way, u_way, free_way, alloc_way;
  logic             l_hit, u_hit;
  logic [CTR_BITS-1:0] u_ctr, u_ctr_next;

  // With a single set there are no index bits; everything lands in set 0.
  if (IDX > 0) begin : g_idx
    assign l_set = pc[IDX+1:2];
    assign u_set = update_pc[IDX+1:2];
  end else begin : g_no_idx
    assign l_set = '0;
    assign u_set = '0;
  end

  assign l_tag = pc[XLEN-1:IDX+2];
  assign u_tag = update_pc[XLEN-1:IDX+2];

  logic unused_ok;
  assign unused_ok = ^{pc[1:0], update_pc[1:0]};

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign l_match[gi] = valid_reg[l_set][gi] && (tag_reg[l_set][gi] == l_tag);
    assign u_match[gi] = valid_reg[u_set][gi] && (tag_reg[u_set][gi] == u_tag);
    assign u_free[gi]  = !valid_reg[u_set][gi];
  end

  // Scan downwards so the lowest-index way wins (matters only for the free-way pick).
  always_comb begin
    l_way    = '0;
    u_way    = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (l_match[w]) l_way    = WAY_W'(w);
      if (u_match[w]) u_way    = WAY_W'(w);
      if (u_free[w])  free_way = WAY_W'(w);
    end
  end

  assign l_hit     = |l_match;
  assign u_hit     = |u_match;
  assign alloc_way = (|u_free) ? free_way : ptr_reg[u_set];

  assign target_pc      = l_hit ? target_reg[l_set][l_way] : pc + XLEN'(4);
  assign valid          = l_hit;
  assign predictedTaken = l_hit && ctr_reg[l_set][l_way][CTR_BITS-1];

  always_comb begin
    u_ctr      = ctr_reg[u_set][u_way];
    u_ctr_next = u_ctr;
    if (update_taken) begin
      if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + CTR_BITS'(1);
    end else begin
      if (u_ctr != '0) u_ctr_next = u_ctr - CTR_BITS'(1);
    end
  end

  // Control state: valid bits, counters and replacement pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          ctr_reg[s][w]   <= CTR_WEAK;
        end
      end
    end else if (flush_all) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_reg[s][w] <= 1'b0;
      end
    end else if (update) begin
      if (u_hit) begin
        ctr_reg[u_set][u_way] <= u_ctr_next;
      end else if (update_taken) begin
        valid_reg[u_set][alloc_way] <= 1'b1;
        ctr_reg[u_set][alloc_way]   <= CTR_WEAK;
        if (!(|u_free) && (WAYS > 1)) ptr_reg[u_set] <= ptr_reg[u_set] + WAY_W'(1);
      end
    end
  end

  // Tag/target payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (update && !flush_all && !rst && update_taken) begin
      if (u_hit) begin
        target_reg[u_set][u_way] <= update_target;
      end else begin
        tag_reg[u_set][alloc_way]    <= u_tag;
        target_reg[u_set][alloc_way] <= update_target;
      end
    end
  end

  logic [2:0]        stat_inc;
  logic [STAT_W-1:0] stat_reg [3];

  assign stat_inc = {mispredicted, lookup_en && l_hit, lookup_en};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       stat_reg[gi] <= '0;
      else if (stat_clear)                           stat_reg[gi] <= '0;
      else if (stat_inc[gi] && (stat_reg[gi] != '1)) stat_reg[gi] <= stat_reg[gi] + STAT_W'(1);
    end
  end

  assign stat_lookups = stat_reg[0];
  assign stat_hits    = stat_reg[1];
  assign stat_mispred = stat_reg[2];

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table, corner sequences and
// randomized traffic checked against a set/way array model of the BTB.
module tb_btb_assoc;
  localparam int SETS = 32;
  localparam int WAYS = 2;
  localparam int CMAX = 3;
  localparam int SMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, target_pc, update_pc = '0, update_target = '0;
  logic        lookup_en = 0, valid, predictedTaken, update = 0, update_taken = 0;
  logic        mispredicted = 0, flush_all = 0, stat_clear = 0;
  logic [3:0]  stat_lookups, stat_hits, stat_mispred;

  always #5 clk = ~clk;

  btb_assoc #(.XLEN(32), .ENTRIES(64), .WAYS(WAYS), .CTR_BITS(2), .STAT_W(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .lookup_en(lookup_en), .target_pc(target_pc),
    .valid(valid), .predictedTaken(predictedTaken), .update(update), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken), .mispredicted(mispredicted),
    .flush_all(flush_all), .stat_clear(stat_clear), .stat_lookups(stat_lookups),
    .stat_hits(stat_hits), .stat_mispred(stat_mispred));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: entries keyed by word address (pc>>2), grouped by set.
  bit          mv [SETS][WAYS];
  int unsigned mk [SETS][WAYS];
  logic [31:0] mt [SETS][WAYS];
  int          mc [SETS][WAYS];
  int          mp [SETS];
  int          st_l, st_h, st_m;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; mc[s][w] = 2; end
    end
    st_l = 0; st_h = 0; st_m = 0;
  endtask

  task automatic model_lookup(input logic [31:0] a, output bit hit, output bit pt, output logic [31:0] tgt);
    int s;
    s = int'((a >> 2) % SETS);
    hit = 0; pt = 0; tgt = a + 32'd4;
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mk[s][w] == (a >> 2)) begin hit = 1; pt = (mc[s][w] >= 2); tgt = mt[s][w]; end
  endtask

  task automatic model_step();
    bit h, p; logic [31:0] t; int s, w;
    model_lookup(pc, h, p, t);
    if (stat_clear) begin st_l = 0; st_h = 0; st_m = 0; end
    else begin
      if (lookup_en && st_l < SMAX) st_l++;
      if (lookup_en && h && st_h < SMAX) st_h++;
      if (mispredicted && st_m < SMAX) st_m++;
    end
    if (flush_all) begin
      for (int i = 0; i < SETS; i++) begin
        mp[i] = 0;
        for (int j = 0; j < WAYS; j++) mv[i][j] = 0;
      end
    end else if (update) begin
      s = int'((update_pc >> 2) % SETS);
      w = -1;
      for (int j = 0; j < WAYS; j++) if (mv[s][j] && mk[s][j] == (update_pc >> 2)) w = j;
      if (w >= 0) begin
        if (update_taken) begin mt[s][w] = update_target; if (mc[s][w] < CMAX) mc[s][w]++; end
        else if (mc[s][w] > 0) mc[s][w]--;
      end else if (update_taken) begin
        for (int j = WAYS - 1; j >= 0; j--) if (!mv[s][j]) w = j;
        if (w < 0) begin w = mp[s]; mp[s] = (mp[s] + 1) % WAYS; end
        mv[s][w] = 1; mk[s][w] = update_pc >> 2; mt[s][w] = update_target; mc[s][w] = 2;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; update = 0; flush_all = 0; stat_clear = 0; lookup_en = 0; mispredicted = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic        upd;
    logic [31:0] upc, utgt;
    logic        utk, fl;
    logic [31:0] lpc;
    logic        ev, ept;
    logic [31:0] etgt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic u, input logic [31:0] upc, utgt, input logic utk, fl,
                     input logic [31:0] lpc, input logic ev, ept, input logic [31:0] etgt);
    vec_t v;
    v.upd = u; v.upc = upc; v.utgt = utgt; v.utk = utk; v.fl = fl;
    v.lpc = lpc; v.ev = ev; v.ept = ept; v.etgt = etgt;
    vecs.push_back(v);
  endtask

  initial begin
    bit h, p; logic [31:0] t;

    // Each row: lookup sees the state before this row's update/flush takes effect.
    add(1, 32'h100, 32'h200, 1, 0, 32'h100, 0, 0, 32'h104);
    add(1, 32'h100, 32'h999, 0, 0, 32'h100, 1, 1, 32'h200);
    add(0, 0, 0, 0, 0,             32'h100, 1, 0, 32'h200);
    add(1, 32'h180, 32'h280, 1, 0, 32'h180, 0, 0, 32'h184);
    add(1, 32'h200, 32'h300, 1, 0, 32'h180, 1, 1, 32'h280);
    add(0, 0, 0, 0, 0,             32'h100, 0, 0, 32'h104);
    add(0, 0, 0, 0, 0,             32'h200, 1, 1, 32'h300);
    add(0, 0, 0, 0, 0,             32'h180, 1, 1, 32'h280);
    add(1, 32'h380, 32'h400, 1, 0, 32'h200, 1, 1, 32'h300);
    add(0, 0, 0, 0, 0,             32'h180, 0, 0, 32'h184);
    add(0, 0, 0, 0, 0,             32'h380, 1, 1, 32'h400);
    for (int i = 0; i < 4; i++) add(1, 32'h380, 32'h400, 1, 0, 32'h380, 1, 1, 32'h400);
    add(1, 32'h380, 32'h400, 0, 0, 32'h380, 1, 1, 32'h400);
    add(1, 32'h380, 32'h400, 0, 0, 32'h380, 1, 1, 32'h400);
    add(1, 32'h380, 32'h400, 0, 0, 32'h380, 1, 0, 32'h400);
    add(1, 32'h380, 32'h400, 0, 0, 32'h380, 1, 0, 32'h400);
    add(1, 32'h380, 32'h400, 0, 0, 32'h380, 1, 0, 32'h400);
    add(0, 0, 0, 0, 0,             32'h380, 1, 0, 32'h400);
    add(1, 32'h380, 32'h500, 1, 0, 32'h380, 1, 0, 32'h400);
    add(0, 0, 0, 0, 0,             32'h380, 1, 0, 32'h500);
    add(1, 32'h300, 32'h600, 0, 0, 32'h380, 1, 0, 32'h500);
    add(0, 0, 0, 0, 0,             32'h300, 0, 0, 32'h304);
    add(1, 32'h400, 32'h700, 1, 1, 32'h200, 1, 1, 32'h300);
    add(0, 0, 0, 0, 0,             32'h400, 0, 0, 32'h404);
    add(0, 0, 0, 0, 0,             32'h200, 0, 0, 32'h204);
    add(0, 0, 0, 0, 0,             32'h380, 0, 0, 32'h384);
    add(0, 0, 0, 0, 0,             32'hFFFF_FFFC, 0, 0, 32'h0);

    // Reset state
    do_reset();
    pc = 32'h100;
    @(negedge clk);
    chk("reset_valid", {31'b0, valid}, 0);
    chk("reset_pt", {31'b0, predictedTaken}, 0);
    chk("reset_target", target_pc, 32'h104);
    chk("reset_stats", {20'b0, stat_lookups, stat_hits, stat_mispred}, 0);
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[i]) begin
      update = vecs[i].upd; update_pc = vecs[i].upc; update_target = vecs[i].utgt;
      update_taken = vecs[i].utk; flush_all = vecs[i].fl; pc = vecs[i].lpc;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_pt", i), {31'b0, predictedTaken}, {31'b0, vecs[i].ept});
      chk($sformatf("vec%0d_target", i), target_pc, vecs[i].etgt);
      @(posedge clk); #1;
    end
    update = 0; flush_all = 0;

    // Statistics saturation and clear priority (4-bit counters)
    do_reset();
    pc = 32'h100; lookup_en = 1;
    for (int i = 0; i < 20; i++) begin
      mispredicted = (i < 3);
      @(posedge clk); #1;
    end
    mispredicted = 0;
    @(negedge clk);
    chk("stat_lookups_sat", {28'b0, stat_lookups}, 15);
    chk("stat_hits_none", {28'b0, stat_hits}, 0);
    chk("stat_mispred_3", {28'b0, stat_mispred}, 3);
    stat_clear = 1;
    @(posedge clk); #1;
    stat_clear = 0; lookup_en = 0;
    @(negedge clk);
    chk("stat_clear_beats_inc", {20'b0, stat_lookups, stat_hits, stat_mispred}, 0);

    // Asynchronous reset between edges drops the entries and a pending update
    do_reset();
    update = 1; update_pc = 32'h100; update_target = 32'h200; update_taken = 1; lookup_en = 1;
    @(posedge clk); #1;
    update_pc = 32'h500; update_target = 32'h900; lookup_en = 0; pc = 32'h100;
    #1 chk("async_pre_hit", {31'b0, valid}, 1);
    #1 rst = 1;
    #1 rst = 0;
    update = 0;
    @(negedge clk);
    chk("async_entry_gone", {31'b0, valid}, 0);
    chk("async_stats_zero", {28'b0, stat_lookups}, 0);
    @(posedge clk); #1;
    pc = 32'h500;
    @(negedge clk);
    chk("async_update_lost", {31'b0, valid}, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pc            = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 2) << 2);
      update        = $urandom_range(0, 1);
      update_pc     = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 2) << 2);
      update_target = $urandom & 32'hFFFF_FFFC;
      update_taken  = ($urandom_range(0, 2) != 0);
      flush_all     = ($urandom_range(0, 39) == 0);
      stat_clear    = ($urandom_range(0, 59) == 0);
      mispredicted  = ($urandom_range(0, 3) == 0);
      lookup_en     = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_lookup(pc, h, p, t);
      chk($sformatf("rnd%0d_valid", i), {31'b0, valid}, {31'b0, h});
      chk($sformatf("rnd%0d_pt", i), {31'b0, predictedTaken}, {31'b0, p});
      chk($sformatf("rnd%0d_target", i), target_pc, t);
      chk($sformatf("rnd%0d_stat_l", i), {28'b0, stat_lookups}, st_l);
      chk($sformatf("rnd%0d_stat_h", i), {28'b0, stat_hits}, st_h);
      chk($sformatf("rnd%0d_stat_m", i), {28'b0, stat_mispred}, st_m);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
